// File: rtl/alarm_controller.sv
// Vehicle alarm main FSM: sequences the shared countdown timer,
// holds the programmable delays and drives siren and status light.
module alarm_controller #(
    parameter int DEF_ARM_DELAY       = 6,
    parameter int DEF_DRIVER_DELAY    = 8,
    parameter int DEF_PASSENGER_DELAY = 15,
    parameter int DEF_ALARM_ON        = 10,
    parameter int GUARD_CYCLES        = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    input  logic       half_hz_enable,
    output logic       start_timer,
    output logic [3:0] interval,
    output logic       siren,
    output logic       status_light,
    output logic [2:0] fsm_state
);

    localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        SOUND      = 3'd2,
        SOUND_HOLD = 3'd3,
        DISARMED   = 3'd4,
        WAIT_OPEN  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ARM_DELAY  = 3'd7
    } state_t;

    state_t        state, state_n;
    logic [GW-1:0] guard, guard_n;
    logic [3:0]    t_arm, t_arm_n;
    logic [3:0]    t_drv, t_drv_n;
    logic [3:0]    t_pas, t_pas_n;
    logic [3:0]    t_alm, t_alm_n;
    logic          start_n;
    logic [3:0]    intv_n;
    logic          siren_n;
    logic          light_n;
    logic          exp_ok;
    logic          any_door;

    assign exp_ok    = expired && (guard == '0);
    assign any_door  = door_driver || door_pass;
    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ARMED;
            guard        <= '0;
            t_arm        <= 4'(DEF_ARM_DELAY);
            t_drv        <= 4'(DEF_DRIVER_DELAY);
            t_pas        <= 4'(DEF_PASSENGER_DELAY);
            t_alm        <= 4'(DEF_ALARM_ON);
            start_timer  <= 1'b0;
            interval     <= 4'd0;
            siren        <= 1'b0;
            status_light <= 1'b0;
        end else begin
            state        <= state_n;
            guard        <= guard_n;
            t_arm        <= t_arm_n;
            t_drv        <= t_drv_n;
            t_pas        <= t_pas_n;
            t_alm        <= t_alm_n;
            start_timer  <= start_n;
            interval     <= intv_n;
            siren        <= siren_n;
            status_light <= light_n;
        end
    end

    always_comb begin
        state_n = state;
        guard_n = (guard != '0) ? guard - GW'(1) : '0;
        t_arm_n = t_arm;
        t_drv_n = t_drv;
        t_pas_n = t_pas;
        t_alm_n = t_alm;
        start_n = 1'b0;
        intv_n  = interval;
        siren_n = siren;
        light_n = status_light;

        if (reprogram) begin
            unique case (time_param_sel)
                2'd0: t_arm_n = time_value;
                2'd1: t_drv_n = time_value;
                2'd2: t_pas_n = time_value;
                2'd3: t_alm_n = time_value;
            endcase
            state_n = ARMED;
            siren_n = 1'b0;
            light_n = 1'b0;
        end else if (ignition && state != DISARMED) begin
            state_n = DISARMED;
            siren_n = 1'b0;
            light_n = 1'b0;
        end else begin
            unique case (state)
                ARMED: begin
                    siren_n = 1'b0;
                    if (half_hz_enable)
                        light_n = ~status_light;
                    // driver door outranks passenger door
                    if (door_driver) begin
                        state_n = TRIGGERED;
                        start_n = 1'b1;
                        intv_n  = t_drv;
                        guard_n = GW'(GUARD_CYCLES);
                        light_n = 1'b1;
                    end else if (door_pass) begin
                        state_n = TRIGGERED;
                        start_n = 1'b1;
                        intv_n  = t_pas;
                        guard_n = GW'(GUARD_CYCLES);
                        light_n = 1'b1;
                    end
                end
                TRIGGERED: begin
                    light_n = 1'b1;
                    if (exp_ok) begin
                        state_n = SOUND;
                        siren_n = 1'b1;
                    end
                end
                SOUND: begin
                    siren_n = 1'b1;
                    light_n = 1'b1;
                    if (!any_door) begin
                        state_n = SOUND_HOLD;
                        start_n = 1'b1;
                        intv_n  = t_alm;
                        guard_n = GW'(GUARD_CYCLES);
                    end
                end
                SOUND_HOLD: begin
                    siren_n = 1'b1;
                    // a reopened door beats a same-cycle expiry
                    if (any_door) begin
                        state_n = SOUND;
                    end else if (exp_ok) begin
                        state_n = ARMED;
                        siren_n = 1'b0;
                        light_n = 1'b0;
                    end
                end
                DISARMED: begin
                    siren_n = 1'b0;
                    light_n = 1'b0;
                    if (!ignition)
                        state_n = WAIT_OPEN;
                end
                WAIT_OPEN: begin
                    light_n = 1'b0;
                    if (door_driver)
                        state_n = WAIT_CLOSE;
                end
                WAIT_CLOSE: begin
                    light_n = 1'b0;
                    if (!door_driver) begin
                        state_n = ARM_DELAY;
                        start_n = 1'b1;
                        intv_n  = t_arm;
                        guard_n = GW'(GUARD_CYCLES);
                    end
                end
                ARM_DELAY: begin
                    light_n = 1'b0;
                    if (any_door) begin
                        state_n = WAIT_CLOSE;
                    end else if (exp_ok) begin
                        state_n = ARMED;
                    end
                end
                default: begin
                    state_n = ARMED;
                    siren_n = 1'b0;
                    light_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: state/siren/light changes and
// timer starts are queued by the stimulus and checked by a monitor.
module tb_alarm_controller;

    localparam logic [2:0] S_ARM = 3'd0, S_TRG = 3'd1, S_SND = 3'd2,
                           S_HLD = 3'd3, S_DIS = 3'd4, S_WOP = 3'd5,
                           S_WCL = 3'd6, S_ADL = 3'd7;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_pass = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_sel = 2'd0;
    logic [3:0] time_value = 4'd0;
    logic       expired = 1'b0;
    logic       half_hz_enable = 1'b0;
    logic       start_timer;
    logic [3:0] interval;
    logic       siren;
    logic       status_light;
    logic [2:0] fsm_state;

    int vecs = 0;
    int miss = 0;

    logic [4:0] sq[$];
    logic [3:0] iq[$];
    logic [4:0] prev = {S_ARM, 1'b0, 1'b0};

    alarm_controller dut (
        .clock(clock),
        .reset(reset),
        .ignition(ignition),
        .door_driver(door_driver),
        .door_pass(door_pass),
        .reprogram(reprogram),
        .time_param_sel(time_param_sel),
        .time_value(time_value),
        .expired(expired),
        .half_hz_enable(half_hz_enable),
        .start_timer(start_timer),
        .interval(interval),
        .siren(siren),
        .status_light(status_light),
        .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        logic [4:0] snap;
        logic [4:0] es;
        logic [3:0] ei;
        snap = {fsm_state, siren, status_light};
        if (snap != prev) begin
            vecs++;
            if (sq.size() == 0) begin
                miss++;
                $display("FAIL state_change unexpected act=%b", snap);
            end else begin
                es = sq.pop_front();
                if (es != snap) begin
                    miss++;
                    $display("FAIL state_change act=%b exp=%b", snap, es);
                end
            end
            prev = snap;
        end
        if (start_timer) begin
            vecs++;
            if (iq.size() == 0) begin
                miss++;
                $display("FAIL start_timer unexpected interval=%0d", interval);
            end else begin
                ei = iq.pop_front();
                if (ei != interval) begin
                    miss++;
                    $display("FAIL interval act=%0d exp=%0d", interval, ei);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic es(input logic [2:0] s, input logic sr, input logic lt);
        sq.push_back({s, sr, lt});
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    initial begin
        ticks(2);
        chk("rst_state", fsm_state, S_ARM);
        chk("rst_siren", siren, 0);
        chk("rst_light", status_light, 0);
        chk("rst_start", start_timer, 0);
        chk("rst_interval", interval, 0);
        reset = 1'b1;
        tick();

        // driver door, guard window, then siren
        es(S_TRG, 0, 1); iq.push_back(4'd8);
        door_driver = 1; tick(); door_driver = 0;
        expired = 1; ticks(2); expired = 0;
        chk("guard_hold", fsm_state, S_TRG);
        tick();
        es(S_SND, 1, 1);
        expired = 1; tick(); expired = 0;
        es(S_HLD, 1, 1); iq.push_back(4'd10);
        tick();
        ticks(2);
        es(S_SND, 1, 1);
        door_pass = 1; expired = 1; tick();
        door_pass = 0; expired = 0;
        es(S_HLD, 1, 1); iq.push_back(4'd10);
        tick();
        expired = 1; ticks(2);
        chk("hold_guard", fsm_state, S_HLD);
        es(S_ARM, 0, 0);
        tick(); expired = 0;

        // door priority and reprogramming
        es(S_TRG, 0, 1); iq.push_back(4'd8);
        door_driver = 1; door_pass = 1; tick();
        door_driver = 0; door_pass = 0;
        es(S_ARM, 0, 0);
        reprogram = 1; time_param_sel = 2'd2; time_value = 4'd15; tick();
        reprogram = 0;
        es(S_TRG, 0, 1); iq.push_back(4'd15);
        door_pass = 1; tick(); door_pass = 0;
        es(S_ARM, 0, 0);
        reprogram = 1; time_param_sel = 2'd1; time_value = 4'd3; tick();
        reprogram = 0;
        es(S_TRG, 0, 1); iq.push_back(4'd3);
        door_driver = 1; tick(); door_driver = 0;
        es(S_SND, 1, 1);
        expired = 1; ticks(3); expired = 0;

        // disarm and arm-delay path
        es(S_DIS, 0, 0);
        door_driver = 1; ignition = 1; tick();
        es(S_WOP, 0, 0);
        ignition = 0; door_driver = 0; tick();
        es(S_WCL, 0, 0);
        door_driver = 1; tick();
        es(S_ADL, 0, 0); iq.push_back(4'd6);
        door_driver = 0; tick();
        es(S_WCL, 0, 0);
        door_driver = 1; tick();
        es(S_ADL, 0, 0); iq.push_back(4'd6);
        door_driver = 0; tick();
        es(S_ARM, 0, 0);
        expired = 1; ticks(3); expired = 0;

        // status light blink
        for (int i = 0; i < 4; i++) begin
            es(S_ARM, 0, (i % 2 == 0));
            half_hz_enable = 1; tick();
            half_hz_enable = 0; tick();
        end

        // async reset in the middle of the arm delay
        es(S_DIS, 0, 0);
        ignition = 1; tick();
        es(S_WOP, 0, 0);
        ignition = 0; tick();
        es(S_WCL, 0, 0);
        door_driver = 1; tick();
        es(S_ADL, 0, 0); iq.push_back(4'd6);
        door_driver = 0; tick();
        tick();
        es(S_ARM, 0, 0);
        reset = 0; #1;
        chk("async_state", fsm_state, S_ARM);
        chk("async_interval", interval, 0);
        chk("async_start", start_timer, 0);
        chk("async_siren", siren, 0);
        ticks(2);
        reset = 1;
        expired = 1; ticks(4); expired = 0;
        chk("stale_expired", fsm_state, S_ARM);
        es(S_TRG, 0, 1); iq.push_back(4'd8);
        door_driver = 1; tick(); door_driver = 0;

        // zero-length delay still waits out the guard
        es(S_ARM, 0, 0);
        reprogram = 1; time_param_sel = 2'd1; time_value = 4'd0; tick();
        reprogram = 0;
        es(S_TRG, 0, 1); iq.push_back(4'd0);
        door_driver = 1; tick(); door_driver = 0;
        expired = 1; ticks(2);
        chk("zero_guard", fsm_state, S_TRG);
        es(S_SND, 1, 1);
        tick(); expired = 0;
        es(S_HLD, 1, 1); iq.push_back(4'd10);
        ticks(4);

        chk("state_queue_left", sq.size(), 0);
        chk("interval_queue_left", iq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Main state machine of the vehicle alarm. Sequences the shared countdown timer for entry delays, arm delay and siren duration.
- Holds the four programmable time parameters and drives the siren and status light.
- Sits between the debounced door/ignition/keypad inputs and the timer block. Its start_timer/interval outputs go to the timer's start_timer/value inputs; the timer's expired and half_hz_enable outputs come back to it.

Parameters:
- DEF_ARM_DELAY, 6, reset value of T_ARM_DELAY (seconds)
- DEF_DRIVER_DELAY, 8, reset value of T_DRIVER_DELAY
- DEF_PASSENGER_DELAY, 15, reset value of T_PASSENGER_DELAY
- DEF_ALARM_ON, 10, reset value of T_ALARM_ON
- GUARD_CYCLES, 2, cycles after a start_timer pulse during which expired is ignored (covers timer load latency)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ignition  in  1  1 = ignition on
- door_driver  in  1  1 = driver door open
- door_pass  in  1  1 = passenger door open
- reprogram  in  1  1-cycle pulse: write time_value into the parameter selected by time_param_sel
- time_param_sel  in  2  0=ARM_DELAY, 1=DRIVER_DELAY, 2=PASSENGER_DELAY, 3=ALARM_ON
- time_value  in  4  new parameter value, seconds
- expired  in  1  from timer; 1 = count reached zero
- half_hz_enable  in  1  from timer; 1-cycle pulse per half-period
- start_timer  out  1  1-cycle pulse; timer loads interval
- interval  out  4  seconds to load; valid while start_timer=1
- siren  out  1  1 = siren sounding
- status_light  out  1  status LED
- fsm_state  out  3  current state encoding (debug)

Behaviour:
- All inputs are already synchronised and debounced upstream. All outputs are registered.
- State encodings: ARMED=0, TRIGGERED=1, SOUND=2, SOUND_HOLD=3, DISARMED=4, WAIT_OPEN=5, WAIT_CLOSE=6, ARM_DELAY=7.
- Reset (reset=0, async) values:
  - state = ARMED.
  - Parameters = DEF_* values.
  - start_timer=0, interval=0, siren=0, status_light=0.
  - Guard counter = 0.
- Start timer action ("start T"):
  - Next cycle: start_timer=1 for exactly one cycle, interval = current value of parameter T.
  - Guard counter loads GUARD_CYCLES and decrements each cycle to 0.
  - expired is acted on only when guard counter == 0.
- Transition priority, highest first: reprogram > ignition=1 > state rules below.
  - reprogram: writes the parameter, state -> ARMED, siren=0, no start_timer. A write with time_value=0 is legal; the next timed state then expires after the guard.
  - ignition=1 in any state other than DISARMED: state -> DISARMED, siren=0.
- ARMED:
  - status_light toggles on each half_hz_enable pulse.
  - door_driver=1 -> TRIGGERED, start T_DRIVER_DELAY.
  - Else door_pass=1 -> TRIGGERED, start T_PASSENGER_DELAY. Driver wins if both doors open in the same cycle.
- TRIGGERED:
  - status_light=1.
  - expired (guard==0) -> SOUND.
  - Further door activity is ignored.
- SOUND:
  - siren=1, status_light=1.
  - Both doors closed -> SOUND_HOLD, start T_ALARM_ON.
- SOUND_HOLD:
  - siren=1.
  - Any door opens -> SOUND; the running timer is abandoned.
  - expired (guard==0) -> ARMED, siren=0.
- DISARMED:
  - siren=0, status_light=0.
  - ignition=0 -> WAIT_OPEN.
- WAIT_OPEN:
  - door_driver=1 -> WAIT_CLOSE.
- WAIT_CLOSE:
  - door_driver=0 -> ARM_DELAY, start T_ARM_DELAY.
- ARM_DELAY:
  - Either door opens -> WAIT_CLOSE; the countdown restarts when the door closes again.
  - expired (guard==0) -> ARMED.
- status_light is forced to 0 on entering ARMED; it then blinks from 0. It is 0 in DISARMED, WAIT_OPEN, WAIT_CLOSE and ARM_DELAY.
- Simultaneous door event and expired in SOUND_HOLD: the door wins; state -> SOUND.
- Reset asserted mid-countdown: state returns to ARMED immediately. Any later expired pulse is ignored because no timed state is active.

Test Plan:
- Reset released, door_driver=1 for 1 cycle -> next cycle state=1, start_timer=1, interval=8; expired held 1 during the 2 guard cycles causes no transition; expired=1 after the guard -> state=2, siren=1.
- ARMED, door_driver=1 and door_pass=1 in the same cycle -> interval=8 (driver priority); repeat with door_pass only -> interval=15.
- SOUND with both doors closed -> SOUND_HOLD, interval=10; door_pass=1 before expired -> SOUND, siren stays 1; close doors, expired -> ARMED, siren=0.
- ignition=1 while in SOUND -> DISARMED, siren=0; ignition=0 -> WAIT_OPEN; driver open/close -> ARM_DELAY, interval=6; reopen the door -> WAIT_CLOSE; close it -> start_timer again with interval=6; expired -> ARMED.
- reprogram with sel=1, value=3 while TRIGGERED -> state=ARMED, siren=0; next driver-door event -> interval=3.
- ARMED with 4 half_hz_enable pulses -> status_light toggles 0→1→0→1→0; reset=0 mid-ARM_DELAY -> outputs return to reset values asynchronously.
